// File: rtl/operand_unpacker.sv
// operand_unpacker
// Walks an inclusive, wrapping range of memory words and streams each
// word to the ALU as two operands over valid/ready, lower half first.
// The loc_o tag uses the same half-select convention as the result buffer.
module operand_unpacker #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  output logic                     mem_re_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     loc_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND_LO,
    SEND_HI,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [ADDR_W-1:0]        cur_addr_q;
  logic [ADDR_W-1:0]        end_addr_q;
  logic [MEM_WORD_SIZE-1:0] word_q;
  logic                     handshake;
  logic                     last_word;

  assign handshake = data_valid_o & data_ready_i;
  assign last_word = (cur_addr_q == end_addr_q);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Range bookkeeping and the word buffer that feeds both operand halves.
  // NOTE: the word buffer is a plain register, not a memory, so it is
  // cleared on reset like the rest; a stale word must never leak out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr_q <= '0;
      end_addr_q <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cur_addr_q <= start_addr_i;
            end_addr_q <= end_addr_i;
          end
        end
        WAIT: begin
          word_q <= mem_rdata_i;
        end
        SEND_HI: begin
          // Wraps naturally at 2^ADDR_W, which is how end < start ranges work.
          if (handshake && !last_word) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; start_i is only looked at in IDLE.
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred when a case arm leaves state_d untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = SEND_LO;
      SEND_LO: if (handshake) state_d = SEND_HI;
      SEND_HI: if (handshake) state_d = last_word ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from state, so async reset forces them low at once.
  always_comb begin
    mem_re_o     = 1'b0;
    mem_addr_o   = '0;
    data_o       = '0;
    data_valid_o = 1'b0;
    loc_o        = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      READ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = cur_addr_q;
      end
      SEND_LO: begin
        data_valid_o = 1'b1;
        data_o       = word_q[DATA_W-1:0];
      end
      SEND_HI: begin
        data_valid_o = 1'b1;
        loc_o        = 1'b1;
        data_o       = word_q[MEM_WORD_SIZE-1:DATA_W];
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/operand_unpacker.md
# operand_unpacker

Reads a range of 64-bit memory words and streams each word out as two DATA_W operands, lower half first, over a valid/ready handshake toward the ALU. It is the read-side counterpart of the result buffer: that block packs two 32-bit results into one memory word selected by loc_sel, and this block unpacks memory words into 32-bit operands tagged with the same half-select convention. It sits between operand SRAM and the adder datapath, under control of the calculator controller.

## Interface
- DATA_W, 32 (calculator_pkg): operand width.
- MEM_WORD_SIZE, 64 (calculator_pkg): memory word width; must equal 2*DATA_W.
- ADDR_W, 10: memory address width.

- clk_i  input  1  clock; all state changes on posedge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  begin unpacking the range; sampled only in IDLE.
- start_addr_i  input  ADDR_W  first word address; latched on accepted start.
- end_addr_i  input  ADDR_W  last word address, inclusive; latched on accepted start.
- mem_re_o  output  1  memory read enable, one-cycle pulse per word.
- mem_addr_o  output  ADDR_W  read address; valid when mem_re_o=1.
- mem_rdata_i  input  MEM_WORD_SIZE  read data, valid exactly 1 cycle after mem_re_o.
- data_o  output  DATA_W  operand out.
- data_valid_o  output  1  data_o valid.
- data_ready_i  input  1  consumer accepts data_o.
- loc_o  output  1  half being presented: 0 = bits [31:0], 1 = bits [63:32].
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse after the last upper half is accepted.

## Operation
- States: IDLE, READ, WAIT, SEND_LO, SEND_HI, DONE.
- IDLE: start_i=1 -> latch start/end, cur_addr <= start_addr_i, go READ. Otherwise stay.
- READ: mem_re_o=1, mem_addr_o=cur_addr; -> WAIT.
- WAIT: capture mem_rdata_i into word register at end of cycle; -> SEND_LO.
- SEND_LO: data_valid_o=1, loc_o=0, data_o=word[DATA_W-1:0]; on data_valid_o&&data_ready_i -> SEND_HI.
- SEND_HI: data_valid_o=1, loc_o=1, data_o=word[MEM_WORD_SIZE-1:DATA_W]; on handshake: cur_addr==end latched -> DONE; else cur_addr <= cur_addr+1, -> READ.
- DONE: done_o=1; -> IDLE.
- Address arithmetic modulo 2^ADDR_W; end < start wraps through max address to end. Words transferred = ((end-start) mod 2^ADDR_W) + 1; start==end transfers exactly one word (two operands).
- start_i while busy_o=1: ignored, no effect on latched range.
- Backpressure: while data_valid_o=1 and data_ready_i=0, data_o, loc_o, data_valid_o held stable; no memory read issued.
- data_o = 0 and loc_o = 0 whenever data_valid_o=0.
- mem_addr_o = 0 whenever mem_re_o=0.

## Timing
- Reset (async, any state, including mid-transfer): state IDLE; mem_re_o, mem_addr_o, data_o, data_valid_o, loc_o, busy_o, done_o all 0; word register and cur_addr cleared. Partially sent word is discarded; no done_o.
- start_i high in cycle 0 -> mem_re_o in cycle 1 -> first data_valid_o in cycle 3.
- With data_ready_i held 1: one handshake per cycle within a word; 4 cycles per word (READ, WAIT, SEND_LO, SEND_HI); done_o in the cycle after the last SEND_HI handshake; IDLE the cycle after.
- Earliest next accepted start: cycle after done_o (IDLE).
- busy_o rises the cycle after accepted start, falls with entry to IDLE.

## Test plan
- Single word: start=end=5, mem[5]=0xAAAA_BBBB_1111_2222, ready=1 -> mem_re_o@cycle1 addr 5; data_o 0x11112222 loc 0 @cycle3, 0xAAAABBBB loc 1 @cycle4, done_o @cycle5.
- Three words 0..2 with ready toggling 1/0 every cycle -> six operands in order lo0,hi0,lo1,hi1,lo2,hi2; data_o stable across every ready=0 cycle; exactly three mem_re_o pulses.
- Wrap: ADDR_W=10, start=1022, end=1 -> reads addresses 1022,1023,0,1 in order, 8 operands, one done_o.
- start_i pulsed with different addresses during busy -> ignored; original range completes unchanged.
- rst_i asserted during SEND_HI of word 2 of 4 -> all outputs 0 immediately (async); no done_o; fresh start afterwards runs correctly from its own start address.
- ready held 0 for 20 cycles in SEND_LO -> data_valid_o stays 1, no mem_re_o, busy_o 1; on ready=1 sequence resumes with no lost or duplicated operand.
